// File: rtl/key_step_gen.sv
// Purpose : debounce a raw push-button and emit one-cycle step pulses, with optional auto-repeat while held.
// Latency : 2-flop synchronizer + DEBOUNCE_CYCLES + 1 edges from first sampled press to oStep/oPressed (registered).
// Backpr. : none; oStep is a fire-and-forget strobe, the downstream counter must accept every pulse.
module key_step_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int CNT_W           = 26
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic iKey,
    input  logic iRepeatEn,
    output logic oStep,
    output logic oPressed
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_DB   = 3'd1,
        S_HELD       = 3'd2,
        S_REPEAT     = 3'd3,
        S_RELEASE_DB = 3'd4
    } state_t;

    // Terminal counts: the timer counts 0..N-1, so expiry is detected at N-1.
    localparam logic [CNT_W-1:0] L_DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] L_RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] L_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] L_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_step;
    logic             r_pressed;
    logic             w_key_s;

    // Two-flop synchronizer bringing the asynchronous key into the CLK domain.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= iKey;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = r_sync2;

    // Debounce / repeat FSM; a released key (key_s=0) always wins over timer expiry.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_timer   <= L_CNT_ZERO;
            r_step    <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_key_s) begin
                        r_state <= S_PRESS_DB;
                        r_timer <= L_CNT_ZERO;
                    end
                end

                S_PRESS_DB: begin
                    if (!w_key_s) begin
                        // Bounce: the key dropped before it was stable long enough.
                        r_state <= S_IDLE;
                        r_timer <= L_CNT_ZERO;
                    end else if (r_timer == L_DB_LAST) begin
                        r_state   <= S_HELD;
                        r_timer   <= L_CNT_ZERO;
                        r_step    <= 1'b1;
                        r_pressed <= 1'b1;
                    end else begin
                        r_timer <= r_timer + L_CNT_ONE;
                    end
                end

                S_HELD: begin
                    if (!w_key_s) begin
                        r_state <= S_RELEASE_DB;
                        r_timer <= L_CNT_ZERO;
                    end else if (!iRepeatEn) begin
                        // Repeat delay only accumulates while repeat is enabled.
                        r_timer <= L_CNT_ZERO;
                    end else if (r_timer == L_RD_LAST) begin
                        r_state <= S_REPEAT;
                        r_timer <= L_CNT_ZERO;
                        r_step  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + L_CNT_ONE;
                    end
                end

                S_REPEAT: begin
                    if (!w_key_s) begin
                        r_state <= S_RELEASE_DB;
                        r_timer <= L_CNT_ZERO;
                    end else if (!iRepeatEn) begin
                        r_state <= S_HELD;
                        r_timer <= L_CNT_ZERO;
                    end else if (r_timer == L_RP_LAST) begin
                        r_timer <= L_CNT_ZERO;
                        r_step  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + L_CNT_ONE;
                    end
                end

                S_RELEASE_DB: begin
                    if (w_key_s) begin
                        // Release bounce: back to HELD silently, repeat delay restarts.
                        r_state <= S_HELD;
                        r_timer <= L_CNT_ZERO;
                    end else if (r_timer == L_DB_LAST) begin
                        r_state   <= S_IDLE;
                        r_timer   <= L_CNT_ZERO;
                        r_pressed <= 1'b0;
                    end else begin
                        r_timer <= r_timer + L_CNT_ONE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_timer   <= L_CNT_ZERO;
                    r_pressed <= 1'b0;
                end
            endcase
        end
    end

    assign oStep    = r_step;
    assign oPressed = r_pressed;

endmodule

// File: tb/tb_key_step_gen.sv
// Purpose : randomized and directed bench for key_step_gen against a run-length reference model.
// Latency : model predicts oStep/oPressed per cycle; directed cases check exact pulse edges.
// Backpr. : none; every DUT pulse is logged and counted.
module tb_key_step_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int CW = 26;

    logic CLK;
    logic rst_n;
    logic iKey;
    logic iRepeatEn;
    logic oStep;
    logic oPressed;

    key_step_gen #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .iKey     (iKey),
        .iRepeatEn(iRepeatEn),
        .oStep    (oStep),
        .oPressed (oPressed)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Posedge counter: at a negedge, cyc is the number of the last rising edge.
    int cyc = 0;
    always @(posedge CLK) cyc++;

    // Reference model: the key as seen after two sample delays, judged by run lengths.
    // A press is accepted after D+1 consecutive high samples, a release after D+1 low ones.
    // While pressed and held with repeat on, pulse when the held-run n reaches RD, then every RP.
    int m_h0, m_h1, m_ones, m_zeros, m_n;
    bit m_pressed, m_step;
    int m_pulses = 0;
    initial begin
        m_h0 = 0; m_h1 = 0; m_ones = 0; m_zeros = 0; m_n = 0;
        m_pressed = 0; m_step = 0;
    end

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_h0 = 0; m_h1 = 0; m_ones = 0; m_zeros = 0; m_n = 0;
            m_pressed = 0; m_step = 0;
        end else begin
            int ks;
            ks   = m_h1;
            m_h1 = m_h0;
            m_h0 = int'(iKey);
            m_step = 0;
            if (!m_pressed) begin
                if (ks != 0) begin
                    m_ones++;
                    if (m_ones == D + 1) begin
                        m_pressed = 1; m_step = 1; m_n = 0; m_zeros = 0; m_ones = 0;
                    end
                end else begin
                    m_ones = 0;
                end
            end else begin
                if (ks == 0) begin
                    m_zeros++;
                    m_n = 0;
                    if (m_zeros == D + 1) begin
                        m_pressed = 0; m_zeros = 0; m_ones = 0;
                    end
                end else if (m_zeros > 0) begin
                    m_zeros = 0; m_n = 0;
                end else if (!iRepeatEn) begin
                    m_n = 0;
                end else begin
                    m_n++;
                    if (m_n == RD || (m_n > RD && (m_n - RD) % RP == 0)) m_step = 1;
                end
            end
            if (m_step) m_pulses++;
        end
    end

    // Per-cycle comparison plus pulse / edge logging for the directed cases.
    int q_pulse[$];
    int dut_pulses = 0;
    int fall_cyc = -1;
    int rise_cyc = -1;
    bit prev_pressed = 0;
    always @(negedge CLK) begin
        chk("step", oStep, m_step);
        chk("pressed", oPressed, m_pressed);
        if (oStep === 1'b1) begin
            q_pulse.push_back(cyc);
            dut_pulses++;
        end
        if (prev_pressed && oPressed !== 1'b1) fall_cyc = cyc;
        if (!prev_pressed && oPressed === 1'b1) rise_cyc = cyc;
        prev_pressed = (oPressed === 1'b1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    int k0, f0, e0, base_m, base_d;
    int offs[6];

    initial begin
        rst_n = 1'b0; iKey = 1'b0; iRepeatEn = 1'b0;
        #12;
        chk("rst_step", oStep, 1'b0);
        chk("rst_pressed", oPressed, 1'b0);
        @(negedge CLK); rst_n = 1'b1;
        cycles(4);

        // 1: clean press, no repeat
        q_pulse.delete();
        iKey = 1'b1; k0 = cyc + 1;
        cycles(20);
        iKey = 1'b0; f0 = cyc + 1;
        cycles(12);
        chk("t1_npulse", q_pulse.size(), 1);
        if (q_pulse.size() > 0) chk("t1_pulse_edge", q_pulse[0], k0 + 6);
        chk("t1_fall_edge", fall_cyc, f0 + 6);

        // 2: bounce 1,1,1,0 x5 is rejected
        q_pulse.delete(); rise_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            iKey = 1'b1; cycles(3);
            iKey = 1'b0; cycles(1);
        end
        cycles(10);
        chk("t2_npulse", q_pulse.size(), 0);
        chk("t2_no_rise", rise_cyc, -1);

        // 3: auto-repeat; release lands on the expiry edge of the 7th pulse
        iRepeatEn = 1'b1; q_pulse.delete();
        iKey = 1'b1; k0 = cyc + 1;
        cycles(29);
        iKey = 1'b0;
        cycles(14);
        iRepeatEn = 1'b0;
        e0 = k0 + 6;
        offs = '{0, 10, 13, 16, 19, 22};
        chk("t3_npulse", q_pulse.size(), 6);
        for (int i = 0; i < 6; i++)
            if (q_pulse.size() > i) chk($sformatf("t3_pulse%0d", i), q_pulse[i], e0 + offs[i]);

        // 4: one-cycle glitch during release debounce
        iKey = 1'b1; cycles(10);
        q_pulse.delete(); fall_cyc = -1;
        iKey = 1'b0; f0 = cyc + 1;
        cycles(3);
        iKey = 1'b1; cycles(1);
        iKey = 1'b0; cycles(5);
        chk("t4_still_pressed", oPressed, 1'b1);
        chk("t4_no_fall_yet", fall_cyc, -1);
        cycles(6);
        chk("t4_fall_edge", fall_cyc, f0 + 10);
        chk("t4_npulse", q_pulse.size(), 0);

        // 5a: reset in the middle of press debounce
        iKey = 1'b1; cycles(4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5a_step", oStep, 1'b0);
        chk("t5a_pressed", oPressed, 1'b0);
        chk("t5a_state", dut.r_state, 0);
        iKey = 1'b0;
        @(negedge CLK); rst_n = 1'b1;
        cycles(10);

        // 5b: reset right after a repeat pulse, key held through reset release
        iRepeatEn = 1'b1;
        iKey = 1'b1; k0 = cyc + 1;
        cycles(20);
        chk("t5b_pulse_before_rst", oStep, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5b_step", oStep, 1'b0);
        chk("t5b_pressed", oPressed, 1'b0);
        chk("t5b_state", dut.r_state, 0);
        iRepeatEn = 1'b0;
        @(negedge CLK);
        q_pulse.delete();
        rst_n = 1'b1; k0 = cyc + 1;
        cycles(20);
        chk("t5b_npulse", q_pulse.size(), 1);
        if (q_pulse.size() > 0) chk("t5b_pulse_edge", q_pulse[0], k0 + 6);
        iKey = 1'b0; cycles(12);

        // 6: 100 random bouncy presses
        base_m = m_pulses; base_d = dut_pulses;
        for (int p = 0; p < 100; p++) begin
            int nb;
            nb = $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
                iKey = 1'b1; cycles($urandom_range(1, 3));
                iKey = 1'b0; cycles($urandom_range(1, 3));
            end
            iKey = 1'b1; cycles($urandom_range(8, 16));
            nb = $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
                iKey = 1'b0; cycles($urandom_range(1, 3));
                iKey = 1'b1; cycles($urandom_range(1, 3));
            end
            iKey = 1'b0; cycles($urandom_range(8, 16));
        end
        cycles(10);
        chk("t6_dut_pulses", dut_pulses - base_d, 100);
        chk("t6_model_pulses", m_pulses - base_m, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
